// File: rtl/axil_master_pkg.sv
// Shared definitions for the AXI4-Lite master: FSM encoding, response codes
// and the default watchdog limit.
package axil_master_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_WRESP = 3'd2;
  localparam logic [2:0] ST_RADDR = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int DEFAULT_TIMEOUT = 255;

  // States in which the master is waiting on the slave and the watchdog runs
  function automatic logic isActive(input logic [2:0] st);
    return (st == ST_WRITE) || (st == ST_WRESP) || (st == ST_RADDR) || (st == ST_RDATA);
  endfunction

endpackage

// File: rtl/axil_master_if.sv
// Command/response port plus AXI4-Lite master bus, bundled for axil_master.
interface axil_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_write;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [DATA_W/8-1:0] cmd_wstrb;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_rdata;
  logic [1:0]          rsp_resp;
  logic                rsp_timeout;
  logic                busy;

  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;
  logic [ADDR_W-1:0]   M_AXI_ARADDR;
  logic                M_AXI_ARVALID;
  logic                M_AXI_ARREADY;
  logic [DATA_W-1:0]   M_AXI_RDATA;
  logic [1:0]          M_AXI_RRESP;
  logic                M_AXI_RVALID;
  logic                M_AXI_RREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, busy,
    output M_AXI_AWADDR, M_AXI_AWVALID, input M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARVALID, input M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, busy,
    input  M_AXI_AWADDR, M_AXI_AWVALID, output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARVALID, output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
  );

endinterface

// File: rtl/axil_timeout.sv
// Watchdog counter: cleared on command accept, counts active cycles and flags
// the cycle in which the running count reaches TIMEOUT (0 disables it).
module axil_timeout
  import axil_master_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Comparing the incremented value makes the abort land exactly TIMEOUT
  // active cycles after the command was accepted
  assign expired = (TIMEOUT != 0) && en && (cnt_d == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axil_master.sv
// AXI4-Lite master: one single-word write or read at a time, driven from a
// valid/ready command port and answered on a valid/ready response port.
module axil_master
  import axil_master_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  axil_master_if.master bus
);

  logic [2:0]          state_q, state_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                arvalid_q, arvalid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;
  logic                timeout_q, timeout_d;
  logic                accept;
  logic                wdExpired;

  assign accept = (state_q == ST_IDLE) && bus.cmd_valid;

  axil_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (isActive(state_q)),
    .expired (wdExpired)
  );

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          wstrb_d = bus.cmd_wstrb;
          if (bus.cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WRITE;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RADDR;
          end
        end
      end
      // AW and W complete independently; move on once both are gone
      ST_WRITE: begin
        if (awvalid_q && bus.M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && bus.M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)        state_d   = ST_WRESP;
      end
      ST_WRESP: begin
        if (bus.M_AXI_BVALID) begin
          resp_d    = bus.M_AXI_BRESP;
          rdata_d   = '0;
          timeout_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_RADDR: begin
        if (bus.M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (bus.M_AXI_RVALID) begin
          rdata_d   = bus.M_AXI_RDATA;
          resp_d    = bus.M_AXI_RRESP;
          timeout_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A hung slave is abandoned outright; it needs a reset before reuse
    if (wdExpired) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      arvalid_d = 1'b0;
      rdata_d   = '0;
      resp_d    = RESP_SLVERR;
      timeout_d = 1'b1;
      state_d   = ST_DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.cmd_ready     = (state_q == ST_IDLE);
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.rsp_valid     = (state_q == ST_DONE);
  assign bus.rsp_rdata     = rdata_q;
  assign bus.rsp_resp      = resp_q;
  assign bus.rsp_timeout   = timeout_q;
  assign bus.M_AXI_AWADDR  = addr_q;
  assign bus.M_AXI_AWVALID = awvalid_q;
  assign bus.M_AXI_WDATA   = wdata_q;
  assign bus.M_AXI_WSTRB   = wstrb_q;
  assign bus.M_AXI_WVALID  = wvalid_q;
  assign bus.M_AXI_BREADY  = (state_q == ST_WRESP);
  assign bus.M_AXI_ARADDR  = addr_q;
  assign bus.M_AXI_ARVALID = arvalid_q;
  assign bus.M_AXI_RREADY  = (state_q == ST_RDATA);

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master against a small model of the accelerator's
// AXI-Lite register slave (one 32-bit register at address 0).
module tb_axil_master;

  logic clk = 1'b0;
  logic rst;
  int   checkCount = 0;
  int   errorCount = 0;

  // Slave model knobs
  logic awreadyEn;
  logic arreadyEn;
  logic bEnable;
  int   wDelay;

  logic [31:0] slaveReg;
  logic        awDone, wDone, arPhase;
  int          wCnt;
  logic        awHs, wHs, arHs;

  always #5 clk = ~clk;

  axil_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axil_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.M_AXI_AWREADY = awreadyEn;
  assign bus.M_AXI_ARREADY = arreadyEn;
  assign bus.M_AXI_WREADY  = (wCnt >= wDelay);
  assign awHs = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
  assign wHs  = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
  assign arHs = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;

  // Slave: B one cycle after both AW and W land; R two cycles after AR (AR1, AR2)
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      slaveReg          <= '0;
      awDone            <= 1'b0;
      wDone             <= 1'b0;
      arPhase           <= 1'b0;
      wCnt              <= 0;
      bus.M_AXI_BVALID  <= 1'b0;
      bus.M_AXI_BRESP   <= 2'b00;
      bus.M_AXI_RVALID  <= 1'b0;
      bus.M_AXI_RDATA   <= '0;
      bus.M_AXI_RRESP   <= 2'b00;
    end else begin
      if (wHs) wCnt <= 0;
      else if (bus.M_AXI_WVALID) wCnt <= wCnt + 1;
      if ((awDone || awHs) && (wDone || wHs)) begin
        awDone           <= 1'b0;
        wDone            <= 1'b0;
        bus.M_AXI_BVALID <= bEnable;
        bus.M_AXI_BRESP  <= 2'b00;
        if (bus.M_AXI_AWADDR == 32'h0) begin
          for (int b = 0; b < 4; b++) begin
            if (bus.M_AXI_WSTRB[b]) slaveReg[8*b +: 8] <= bus.M_AXI_WDATA[8*b +: 8];
          end
        end
      end else begin
        if (awHs) awDone <= 1'b1;
        if (wHs)  wDone  <= 1'b1;
      end
      if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) bus.M_AXI_BVALID <= 1'b0;
      if (arHs) arPhase <= 1'b1;
      if (arPhase) begin
        arPhase          <= 1'b0;
        bus.M_AXI_RVALID <= 1'b1;
        bus.M_AXI_RDATA  <= slaveReg;
        bus.M_AXI_RRESP  <= 2'b00;
      end
      if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) bus.M_AXI_RVALID <= 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
    bus.cmd_wstrb = strb;
  endtask

  // Called at a falling edge in IDLE with rsp_ready high; returns at a falling edge in IDLE
  task automatic runCommand(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb, input int expLat,
                            input logic [31:0] expRdata, input logic [1:0] expResp,
                            input logic expTimeout);
    int lat;
    lat = 0;
    applyStimulus(wr, addr, data, strb);
    do begin
      @(negedge clk);
      lat++;
      bus.cmd_valid = 1'b0;
    end while (!bus.rsp_valid && lat < 64);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_rdata"}, bus.rsp_rdata, expRdata);
    checkOutput({tag, "_resp"}, 32'(bus.rsp_resp), 32'(expResp));
    checkOutput({tag, "_timeout"}, 32'(bus.rsp_timeout), 32'(expTimeout));
    checkOutput({tag, "_breadyInDone"}, 32'(bus.M_AXI_BREADY), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_cmdReadyAfter"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_wstrb = '0;
    bus.rsp_ready = 1'b1;
    awreadyEn     = 1'b1;
    arreadyEn     = 1'b1;
    bEnable       = 1'b1;
    wDelay        = 0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);

    checkOutput("rst_cmdReady", 32'(bus.cmd_ready), 32'd1);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_axiHandshakes", 32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                                          bus.M_AXI_BREADY, bus.M_AXI_RREADY}), 32'd0);
    checkOutput("rst_rsp", 32'({bus.rsp_valid, bus.rsp_timeout, bus.rsp_resp}), 32'd0);
    checkOutput("rst_rdata", bus.rsp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] write/read round trips");
    runCommand("wr2", 1'b1, 32'h0, 32'h2, 4'hF, 3, 32'h0, 2'b00, 1'b0);
    runCommand("rd2", 1'b0, 32'h0, 32'h0, 4'h0, 4, 32'h2, 2'b00, 1'b0);
    runCommand("wr1", 1'b1, 32'h0, 32'h1, 4'hF, 3, 32'h0, 2'b00, 1'b0);
    runCommand("rd1", 1'b0, 32'h0, 32'h0, 4'h0, 4, 32'h1, 2'b00, 1'b0);

    $display("[TB] WREADY delayed by 5 cycles");
    wDelay = 5;
    applyStimulus(1'b1, 32'h0, 32'hAABBCC03, 4'h1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checkOutput("dly_c1_awvalid", 32'(bus.M_AXI_AWVALID), 32'd1);
    checkOutput("dly_c1_wvalid", 32'(bus.M_AXI_WVALID), 32'd1);
    checkOutput("dly_c1_wdata", bus.M_AXI_WDATA, 32'hAABBCC03);
    @(negedge clk);
    checkOutput("dly_c2_awvalid", 32'(bus.M_AXI_AWVALID), 32'd0);
    for (int c = 2; c <= 6; c++) begin
      if (c > 2) @(negedge clk);
      checkOutput($sformatf("dly_c%0d_wvalid", c), 32'(bus.M_AXI_WVALID), 32'd1);
      checkOutput($sformatf("dly_c%0d_bready", c), 32'(bus.M_AXI_BREADY), 32'd0);
    end
    @(negedge clk);
    checkOutput("dly_c7_wvalid", 32'(bus.M_AXI_WVALID), 32'd0);
    checkOutput("dly_c7_bready", 32'(bus.M_AXI_BREADY), 32'd1);
    @(negedge clk);
    checkOutput("dly_c8_rspValid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("dly_c8_resp", 32'(bus.rsp_resp), 32'd0);
    @(negedge clk);
    checkOutput("dly_c9_cmdReady", 32'(bus.cmd_ready), 32'd1);
    wDelay = 0;
    runCommand("rdStrb", 1'b0, 32'h0, 32'h0, 4'h0, 4, 32'h3, 2'b00, 1'b0);

    $display("[TB] response held off for 10 cycles");
    bus.rsp_ready = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("hold_c4_rspValid", 32'(bus.rsp_valid), 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput($sformatf("hold_%0d_rspValid", c), 32'(bus.rsp_valid), 32'd1);
      checkOutput($sformatf("hold_%0d_rdata", c), bus.rsp_rdata, 32'h3);
      checkOutput($sformatf("hold_%0d_cmdReady", c), 32'(bus.cmd_ready), 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("hold_next_cmdReady", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checkOutput("hold_next_arvalid", 32'(bus.M_AXI_ARVALID), 32'd1);
    checkOutput("hold_next_busy", 32'(bus.busy), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("hold_next_rspValid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("hold_next_rdata", bus.rsp_rdata, 32'h3);
    @(negedge clk);

    $display("[TB] reset while ARVALID is high");
    arreadyEn = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checkOutput("rstmid_arvalidBefore", 32'(bus.M_AXI_ARVALID), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstmid_arvalid", 32'(bus.M_AXI_ARVALID), 32'd0);
    checkOutput("rstmid_idle", 32'({bus.busy, bus.cmd_ready}), 32'b01);
    checkOutput("rstmid_rdata", bus.rsp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    arreadyEn = 1'b1;
    @(negedge clk);
    runCommand("rdAfterRst", 1'b0, 32'h0, 32'h0, 4'h0, 4, 32'h0, 2'b00, 1'b0);

    $display("[TB] slave never answers B");
    bEnable = 1'b0;
    runCommand("tmo", 1'b1, 32'h0, 32'h55, 4'hF, 17, 32'h0, 2'b10, 1'b1);
    checkOutput("tmo_breadyAfter", 32'(bus.M_AXI_BREADY), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("tmo_rstClears", 32'({bus.rsp_timeout, bus.rsp_resp}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bEnable = 1'b1;
    @(negedge clk);
    runCommand("wrAfterTmo", 1'b1, 32'h0, 32'h7, 4'hF, 3, 32'h0, 2'b00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/axil_master.md
# axil_master

AXI4-Lite master (initiator) that turns single-word commands from a simple valid/ready request port into AXI-Lite write or read transactions. It is the counterpart of the accelerator's AXI-Lite slave register block. It drives the slave's control register (address 0: `{com, run}`) from a bench or an on-fabric sequencer, and returns the response on a valid/ready response port. Only one transaction is in flight at a time. A watchdog aborts the transaction if the slave hangs.

## Interface
Parameters:
- ADDR_W, 32, AXI address width
- DATA_W, 32, AXI data width; WSTRB width is DATA_W/8
- TIMEOUT, 255, cycles allowed from command accept to B/R handshake; 0 disables the watchdog

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  single clock for every port
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  DATA_W/8  write strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
- rsp_resp  out  2  BRESP/RRESP as received; 2'b10 on timeout
- rsp_timeout  out  1  response was produced by the watchdog
- busy  out  1  state != IDLE
- M_AXI_AWADDR/AWVALID out, M_AXI_AWREADY in
- M_AXI_WDATA/WSTRB/WVALID out, M_AXI_WREADY in
- M_AXI_BRESP/BVALID in, M_AXI_BREADY out
- M_AXI_ARADDR/ARVALID out, M_AXI_ARREADY in
- M_AXI_RDATA/RRESP/RVALID in, M_AXI_RREADY out

## Operation
- States: IDLE, WRITE (AW and/or W pending), WRESP, RADDR, RDATA, DONE.
- IDLE: cmd_valid & cmd_ready latches addr, wdata, wstrb and write.
  - Write: go to WRITE with AWVALID=WVALID=1.
  - Read: go to RADDR with ARVALID=1.
- WRITE: AWVALID and WVALID are independent flags. Each flag clears on its own handshake, in any order or in the same cycle. When both have cleared, go to WRESP.
- WRESP: BREADY=1. On BVALID, capture BRESP, set rdata=0, go to DONE.
- RADDR: on ARREADY, clear ARVALID and go to RDATA.
- RDATA: RREADY=1. On RVALID, capture RDATA and RRESP, go to DONE.
- DONE: rsp_valid=1. On rsp_ready, go to IDLE.
- Watchdog:
  - Counter clears on command accept and increments in WRITE, WRESP, RADDR and RDATA.
  - When the count equals TIMEOUT, all M_AXI valids and readies drop and the block goes to DONE with rsp_resp=2'b10, rsp_timeout=1, rdata=0.
  - A timeout abort is a deliberate AXI violation. The slave must be reset before it is used again.
- AXI payload (AWADDR, WDATA, WSTRB, ARADDR) is driven from the latched registers and is held stable while the matching valid is high.

## Timing
- Reset: state=IDLE, every M_AXI valid/ready=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0, counter=0.
  - Reset takes effect immediately, including mid-transaction.
- All outputs are registered or decoded from state only. No combinational path from any input to any output.
- Command accepted at cycle 0 → AWVALID/WVALID (or ARVALID) high at cycle 1.
- A ready-to-valid handshake at cycle N clears the matching valid at cycle N+1.
- BVALID/RVALID seen at cycle N → rsp_valid at N+1.
- Latency against the accelerator slave, with rsp_ready held high:
  - Write: rsp_valid at cycle 3.
  - Read: rsp_valid at cycle 4 (slave states AR1, then AR2).
- cmd_ready returns the cycle after the rsp handshake. Back-to-back command spacing is therefore at least latency+1.
- A timeout at count==TIMEOUT gives rsp_valid on the next cycle.

## Structure
- Shared package holds:
  - State encoding.
  - AXI response codes: OKAY=2'b00, SLVERR=2'b10.
  - Default TIMEOUT.
- Sub-module: axil_timeout, the watchdog counter.
  - Inputs: clr, en.
  - Output: expired.

## Test plan
- Write addr 0x0, data 0x2, wstrb 0xF, against the accelerator slave → rsp_valid at cycle 3, rsp_resp=0; slave read of address 0 then returns 0x2.
- Read addr 0x0 after writing 0x1 → rsp_rdata[1:0]=2'b01, rsp_resp=0, rsp_valid at cycle 4.
- Slave model with WREADY delayed 5 cycles and AWREADY immediate → AWVALID drops at cycle 2, WVALID stays high until the handshake, BREADY does not assert before both have cleared.
- Slave that never asserts BVALID, TIMEOUT=16 → rsp_valid at cycle 17, rsp_resp=2'b10, rsp_timeout=1, BREADY low afterwards.
- rsp_ready held low 10 cycles in DONE → rsp_valid and rsp_rdata stable, cmd_ready low; a second command is accepted the cycle after rsp_ready rises.
- rst asserted while ARVALID=1 → ARVALID=0 and state=IDLE immediately; the next read completes normally.
